// File: rtl/ahb_decoder_mux_if.sv
// AHB-Lite bundle around the decoder: master request, per-slot selects/responses, shared response.
// 'slave' is the decoder's view; 'master' is the surrounding bus (master plus slave slots).
interface ahb_decoder_mux_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;

  logic        HSEL_S0;
  logic        HSEL_S1;
  logic        HSEL_S2;
  logic        HSEL_S3;

  logic        HREADYOUT_S0;
  logic        HREADYOUT_S1;
  logic        HREADYOUT_S2;
  logic        HREADYOUT_S3;

  logic [31:0] HRDATA_S0;
  logic [31:0] HRDATA_S1;
  logic [31:0] HRDATA_S2;
  logic [31:0] HRDATA_S3;

  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE,
    output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
    output HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
    input  HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE,
    input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
    input  HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
    output HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3,
    output HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder, slave multiplexer and built-in default slave (two-cycle ERROR).
// Optional feature: define AHB_DECMUX_WPROT_EN to make slot 0 write-protected.
module ahb_decoder_mux #(
  parameter logic [3:0] S0_BASE = 4'h0,
  parameter logic [3:0] S1_BASE = 4'h5,
  parameter logic [3:0] S2_BASE = 4'h6,
  parameter logic [3:0] S3_BASE = 4'h7
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_decoder_mux_if.slave bus
);

  typedef enum logic [2:0] {
    DSEL_NONE = 3'd0,
    DSEL_S0   = 3'd1,
    DSEL_S1   = 3'd2,
    DSEL_S2   = 3'd3,
    DSEL_S3   = 3'd4,
    DSEL_DEF  = 3'd5
  } dsel_e;

  typedef enum logic [1:0] {
    DEF_IDLE = 2'd0,
    DEF_ERR1 = 2'd1,
    DEF_ERR2 = 2'd2
  } def_state_e;

  logic [3:0]  slot_s;
  logic        m0_s;
  logic        m1_s;
  logic        m2_s;
  logic        m3_s;
  logic        wprot_s;
  logic [3:0]  sel_s;
  logic        def_sel_s;
  logic        err_req_s;
  dsel_e       dec_s;

  dsel_e       dsel_d;
  dsel_e       dsel_q;

  def_state_e  def_state_q;
  logic        def_ready_q;
  logic        def_resp_q;

  logic        hready_s;
  logic [31:0] hrdata_s;
  logic        hresp_s;

  // Address-phase decode; lower slots win if two bases are configured equal.
  always_comb begin
    slot_s = bus.HADDR[31:28];
    m0_s   = (slot_s == S0_BASE);
    m1_s   = (slot_s == S1_BASE) & ~m0_s;
    m2_s   = (slot_s == S2_BASE) & ~m0_s & ~m1_s;
    m3_s   = (slot_s == S3_BASE) & ~m0_s & ~m1_s & ~m2_s;
`ifdef AHB_DECMUX_WPROT_EN
    wprot_s = m0_s & bus.HWRITE & bus.HTRANS[1];
`else
    wprot_s = 1'b0;
`endif
    sel_s     = {m3_s, m2_s, m1_s, m0_s & ~wprot_s};
    def_sel_s = ~(|sel_s);
    err_req_s = def_sel_s & bus.HTRANS[1];
    if (sel_s[0]) begin
      dec_s = DSEL_S0;
    end else if (sel_s[1]) begin
      dec_s = DSEL_S1;
    end else if (sel_s[2]) begin
      dec_s = DSEL_S2;
    end else if (sel_s[3]) begin
      dec_s = DSEL_S3;
    end else begin
      dec_s = DSEL_DEF;
    end
  end

  // Shared response mux driven by the slot that owns the current data phase.
  always_comb begin
    case (dsel_q)
      DSEL_S0: begin
        hready_s = bus.HREADYOUT_S0;
        hrdata_s = bus.HRDATA_S0;
        hresp_s  = 1'b0;
      end
      DSEL_S1: begin
        hready_s = bus.HREADYOUT_S1;
        hrdata_s = bus.HRDATA_S1;
        hresp_s  = 1'b0;
      end
      DSEL_S2: begin
        hready_s = bus.HREADYOUT_S2;
        hrdata_s = bus.HRDATA_S2;
        hresp_s  = 1'b0;
      end
      DSEL_S3: begin
        hready_s = bus.HREADYOUT_S3;
        hrdata_s = bus.HRDATA_S3;
        hresp_s  = 1'b0;
      end
      DSEL_DEF: begin
        hready_s = def_ready_q;
        hrdata_s = 32'h0000_0000;
        hresp_s  = def_resp_q;
      end
      default: begin
        hready_s = 1'b1;
        hrdata_s = 32'h0000_0000;
        hresp_s  = 1'b0;
      end
    endcase
  end

  // Data-phase owner advances only when the bus is ready, so wait states freeze the decode.
  always_comb begin
    if (hready_s) begin
      dsel_d = dec_s;
    end else begin
      dsel_d = dsel_q;
    end
  end

  // Data-phase select register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q <= DSEL_NONE;
    end else begin
      dsel_q <= dsel_d;
    end
  end

  // Default slave: ERR1 (wait, ERROR) then ERR2 (ready, ERROR); ERR2 may chain straight into ERR1.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      def_state_q <= DEF_IDLE;
      def_ready_q <= 1'b1;
      def_resp_q  <= 1'b0;
    end else begin
      case (def_state_q)
        DEF_IDLE: begin
          if (hready_s & err_req_s) begin
            def_state_q <= DEF_ERR1;
            def_ready_q <= 1'b0;
            def_resp_q  <= 1'b1;
          end else begin
            def_state_q <= DEF_IDLE;
            def_ready_q <= 1'b1;
            def_resp_q  <= 1'b0;
          end
        end
        DEF_ERR1: begin
          def_state_q <= DEF_ERR2;
          def_ready_q <= 1'b1;
          def_resp_q  <= 1'b1;
        end
        DEF_ERR2: begin
          if (err_req_s) begin
            def_state_q <= DEF_ERR1;
            def_ready_q <= 1'b0;
            def_resp_q  <= 1'b1;
          end else begin
            def_state_q <= DEF_IDLE;
            def_ready_q <= 1'b1;
            def_resp_q  <= 1'b0;
          end
        end
        default: begin
          def_state_q <= DEF_IDLE;
          def_ready_q <= 1'b1;
          def_resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HSEL_S0 = sel_s[0];
  assign bus.HSEL_S1 = sel_s[1];
  assign bus.HSEL_S2 = sel_s[2];
  assign bus.HSEL_S3 = sel_s[3];
  assign bus.HREADY  = hready_s;
  assign bus.HRDATA  = hrdata_s;
  assign bus.HRESP   = hresp_s;

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed bench for ahb_decoder_mux: slot 0 is a small memory model, slots 1-3 return fixed data.
module tb_ahb_decoder_mux;

  localparam logic [31:0] S1_DATA = 32'h1111_1111;
  localparam logic [31:0] S2_DATA = 32'h2222_2222;
  localparam logic [31:0] S3_DATA = 32'h3333_3333;

  logic        HCLK;
  logic        HRESETn;
  logic        s1_ready;
  logic [31:0] hwdata;
  int          total;
  int          passed;

  ahb_decoder_mux_if bus_if ();

  ahb_decoder_mux dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus_if)
  );

  logic [31:0] mem [0:15];
  logic        s0_dph;
  logic        s0_dwr;
  logic [3:0]  s0_idx;

  assign bus_if.HREADYOUT_S0 = 1'b1;
  assign bus_if.HREADYOUT_S1 = s1_ready;
  assign bus_if.HREADYOUT_S2 = 1'b1;
  assign bus_if.HREADYOUT_S3 = 1'b1;
  assign bus_if.HRDATA_S0    = s0_dph ? mem[s0_idx] : 32'h0000_0000;
  assign bus_if.HRDATA_S1    = S1_DATA;
  assign bus_if.HRDATA_S2    = S2_DATA;
  assign bus_if.HRDATA_S3    = S3_DATA;

  // Slot 0 memory model: captures its address phase, writes at the end of the data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s0_dph <= 1'b0;
      s0_dwr <= 1'b0;
      s0_idx <= 4'h0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      mem[4] <= 32'hCAFE_F00D;
    end else if (bus_if.HREADY) begin
      if (s0_dph && s0_dwr) mem[s0_idx] <= hwdata;
      s0_dph <= bus_if.HSEL_S0 & bus_if.HTRANS[1];
      s0_dwr <= bus_if.HWRITE;
      s0_idx <= bus_if.HADDR[5:2];
    end
  end

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans, input logic wr);
    bus_if.HADDR  = addr;
    bus_if.HTRANS = trans;
    bus_if.HWRITE = wr;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge HCLK);
    drive(32'h9000_0000, 2'b10, 1'b0);
    #1;
    total++; if (bus_if.HREADY !== 1'b1) $display("FAIL rst_hready: got %b expected %b", bus_if.HREADY, 1'b1); else passed++;
    total++; if (bus_if.HRESP !== 1'b0) $display("FAIL rst_hresp: got %b expected %b", bus_if.HRESP, 1'b0); else passed++;
    total++; if (bus_if.HRDATA !== 32'h0000_0000) $display("FAIL rst_hrdata: got %h expected %h", bus_if.HRDATA, 32'h0000_0000); else passed++;
    total++; if ({bus_if.HSEL_S3, bus_if.HSEL_S2, bus_if.HSEL_S1, bus_if.HSEL_S0} !== 4'b0000) $display("FAIL rst_hsel_unmapped: got %b expected %b", {bus_if.HSEL_S3, bus_if.HSEL_S2, bus_if.HSEL_S1, bus_if.HSEL_S0}, 4'b0000); else passed++;
    drive(32'h5000_0000, 2'b10, 1'b0);
    #1;
    total++; if ({bus_if.HSEL_S3, bus_if.HSEL_S2, bus_if.HSEL_S1, bus_if.HSEL_S0} !== 4'b0010) $display("FAIL rst_hsel_s1: got %b expected %b", {bus_if.HSEL_S3, bus_if.HSEL_S2, bus_if.HSEL_S1, bus_if.HSEL_S0}, 4'b0010); else passed++;
    drive(32'h0000_0000, 2'b00, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    cyc();
    total++; if (bus_if.HREADY !== 1'b1) $display("FAIL rst_release_hready: got %b expected %b", bus_if.HREADY, 1'b1); else passed++;
  endtask

  task automatic test_read_s0();
    drive(32'h0000_0010, 2'b10, 1'b0);
    #1;
    total++; if ({bus_if.HSEL_S3, bus_if.HSEL_S2, bus_if.HSEL_S1, bus_if.HSEL_S0} !== 4'b0001) $display("FAIL rd_s0_hsel: got %b expected %b", {bus_if.HSEL_S3, bus_if.HSEL_S2, bus_if.HSEL_S1, bus_if.HSEL_S0}, 4'b0001); else passed++;
    cyc();
    total++; if (bus_if.HRDATA !== 32'hCAFE_F00D) $display("FAIL rd_s0_hrdata: got %h expected %h", bus_if.HRDATA, 32'hCAFE_F00D); else passed++;
    total++; if (bus_if.HREADY !== 1'b1) $display("FAIL rd_s0_hready: got %b expected %b", bus_if.HREADY, 1'b1); else passed++;
    total++; if (bus_if.HRESP !== 1'b0) $display("FAIL rd_s0_hresp: got %b expected %b", bus_if.HRESP, 1'b0); else passed++;
    drive(32'h0000_0000, 2'b00, 1'b0);
    cyc();
  endtask

  task automatic test_decode_slots();
    logic [31:0] exp_data;
    for (int i = 1; i < 4; i++) begin
      exp_data = (i == 1) ? S1_DATA : ((i == 2) ? S2_DATA : S3_DATA);
      drive({4'(i + 4), 28'h000_0100}, 2'b10, 1'b0);
      #1;
      total++; if ({bus_if.HSEL_S3, bus_if.HSEL_S2, bus_if.HSEL_S1, bus_if.HSEL_S0} !== (4'b0001 << i)) $display("FAIL slot%0d_hsel: got %b expected %b", i, {bus_if.HSEL_S3, bus_if.HSEL_S2, bus_if.HSEL_S1, bus_if.HSEL_S0}, 4'b0001 << i); else passed++;
      cyc();
      total++; if (bus_if.HRDATA !== exp_data) $display("FAIL slot%0d_hrdata: got %h expected %h", i, bus_if.HRDATA, exp_data); else passed++;
      total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b10) $display("FAIL slot%0d_resp: got ready/resp %b expected %b", i, {bus_if.HREADY, bus_if.HRESP}, 2'b10); else passed++;
      drive(32'h0000_0000, 2'b00, 1'b0);
      cyc();
    end
  endtask

  task automatic test_wait_s1();
    drive(32'h5000_0000, 2'b10, 1'b1);
    cyc();
    s1_ready = 1'b0;
    drive(32'h0000_0000, 2'b10, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus_if.HREADY !== 1'b0) $display("FAIL wait_low%0d: got hready %b expected %b", i, bus_if.HREADY, 1'b0); else passed++;
      total++; if (bus_if.HRDATA !== S1_DATA) $display("FAIL wait_dsel%0d: got hrdata %h expected %h", i, bus_if.HRDATA, S1_DATA); else passed++;
      if (i < 2) cyc();
    end
    @(posedge HCLK);
    #1;
    s1_ready = 1'b1;
    #1;
    total++; if (bus_if.HREADY !== 1'b1) $display("FAIL wait_release: got hready %b expected %b", bus_if.HREADY, 1'b1); else passed++;
    cyc();
    drive(32'h0000_0000, 2'b00, 1'b0);
    total++; if (bus_if.HRDATA !== 32'hA5A5_0000) $display("FAIL wait_next_rd: got %h expected %h", bus_if.HRDATA, 32'hA5A5_0000); else passed++;
    cyc();
  endtask

  task automatic test_default_err();
    drive(32'h9000_0000, 2'b10, 1'b0);
    #1;
    total++; if ({bus_if.HSEL_S3, bus_if.HSEL_S2, bus_if.HSEL_S1, bus_if.HSEL_S0} !== 4'b0000) $display("FAIL def_hsel: got %b expected %b", {bus_if.HSEL_S3, bus_if.HSEL_S2, bus_if.HSEL_S1, bus_if.HSEL_S0}, 4'b0000); else passed++;
    cyc();
    drive(32'h0000_0000, 2'b00, 1'b0);
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b01) $display("FAIL def_err1: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b01); else passed++;
    total++; if (bus_if.HRDATA !== 32'h0000_0000) $display("FAIL def_hrdata: got %h expected %h", bus_if.HRDATA, 32'h0000_0000); else passed++;
    cyc();
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b11) $display("FAIL def_err2: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b11); else passed++;
    cyc();
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b10) $display("FAIL def_okay_after: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b10); else passed++;
  endtask

  task automatic test_back_to_back();
    drive(32'hA000_0000, 2'b10, 1'b0);
    cyc();
    drive(32'hB000_0000, 2'b10, 1'b0);
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b01) $display("FAIL b2b_err1a: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b01); else passed++;
    cyc();
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b11) $display("FAIL b2b_err2a: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b11); else passed++;
    cyc();
    drive(32'h9000_0000, 2'b00, 1'b0);
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b01) $display("FAIL b2b_err1b: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b01); else passed++;
    cyc();
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b11) $display("FAIL b2b_err2b: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b11); else passed++;
    cyc();
    drive(32'h0000_0000, 2'b00, 1'b0);
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b10) $display("FAIL b2b_idle_okay: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b10); else passed++;
    cyc();
  endtask

  task automatic test_reset_mid();
    drive(32'h9000_0000, 2'b10, 1'b0);
    cyc();
    drive(32'h0000_0000, 2'b00, 1'b0);
    total++; if (bus_if.HREADY !== 1'b0) $display("FAIL rm_err1: got hready %b expected %b", bus_if.HREADY, 1'b0); else passed++;
    HRESETn = 1'b0;
    #1;
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b10) $display("FAIL rm_async: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b10); else passed++;
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b10) $display("FAIL rm_release: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b10); else passed++;
    cyc();
    drive(32'h0000_0010, 2'b10, 1'b0);
    cyc();
    drive(32'h0000_0000, 2'b00, 1'b0);
    total++; if (bus_if.HRDATA !== 32'hCAFE_F00D) $display("FAIL rm_read: got %h expected %h", bus_if.HRDATA, 32'hCAFE_F00D); else passed++;
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b10) $display("FAIL rm_read_resp: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b10); else passed++;
    cyc();
  endtask

  task automatic test_wprot();
    logic        exp_sel0;
    logic [31:0] exp_rd;
`ifdef AHB_DECMUX_WPROT_EN
    exp_sel0 = 1'b0;
    exp_rd   = 32'hA5A5_0001;
`else
    exp_sel0 = 1'b1;
    exp_rd   = 32'hDEAD_BEEF;
`endif
    drive(32'h0000_0004, 2'b10, 1'b1);
    #1;
    total++; if (bus_if.HSEL_S0 !== exp_sel0) $display("FAIL wp_hsel0: got %b expected %b", bus_if.HSEL_S0, exp_sel0); else passed++;
    cyc();
    hwdata = 32'hDEAD_BEEF;
    drive(32'h0000_0000, 2'b00, 1'b0);
    #1;
`ifdef AHB_DECMUX_WPROT_EN
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b01) $display("FAIL wp_err1: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b01); else passed++;
    cyc();
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b11) $display("FAIL wp_err2: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b11); else passed++;
    cyc();
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b10) $display("FAIL wp_after: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b10); else passed++;
`else
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b10) $display("FAIL wp_write_okay: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b10); else passed++;
    cyc();
`endif
    drive(32'h0000_0004, 2'b10, 1'b0);
    cyc();
    drive(32'h0000_0000, 2'b00, 1'b0);
    total++; if (bus_if.HRDATA !== exp_rd) $display("FAIL wp_readback: got %h expected %h", bus_if.HRDATA, exp_rd); else passed++;
    total++; if ({bus_if.HREADY, bus_if.HRESP} !== 2'b10) $display("FAIL wp_read_resp: got ready/resp %b expected %b", {bus_if.HREADY, bus_if.HRESP}, 2'b10); else passed++;
    cyc();
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    HRESETn  = 1'b0;
    s1_ready = 1'b1;
    hwdata   = 32'h0000_0000;
    drive(32'h0000_0000, 2'b00, 1'b0);
    test_reset();
    test_read_s0();
    test_decode_slots();
    test_wait_s1();
    test_default_err();
    test_back_to_back();
    test_reset_mid();
    test_wprot();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
